// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the multi-channel audio mixer and its PWM output stage.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } mix_state_e;

    // Width of the generic saturation datapath; any accumulator narrower than this fits.
    localparam int unsigned SatW = 64;

    typedef struct packed {
        logic signed [SatW-1:0] value;
        logic                   clipped;
    } sat_t;

    function automatic int unsigned acc_width(input int unsigned channels,
                                              input int unsigned a_bits);
        return a_bits + $clog2(channels) + 1;
    endfunction

    function automatic sat_t sat_signed(input logic signed [SatW-1:0] acc,
                                        input int unsigned            a_bits);
        logic signed [SatW-1:0] max_v;
        logic signed [SatW-1:0] min_v;
        sat_t                   res;
        max_v       = $signed((64'd1 << (a_bits - 1)) - 64'd1);
        min_v       = -max_v - 64'sd1;
        res.clipped = 1'b1;
        if (acc > max_v) begin
            res.value = max_v;
        end else if (acc < min_v) begin
            res.value = min_v;
        end else begin
            res.value   = acc;
            res.clipped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_mix_pwm_if.sv
// Sample-frame handshake between a producer core and the audio mixer.
interface audio_mix_pwm_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned A_BITS   = 11,
    parameter int unsigned VOL_BITS = 3
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*A_BITS-1:0]   in_samples;
    logic [CHANNELS*VOL_BITS-1:0] in_vol;

    modport master (
        output in_valid,
        output in_samples,
        output in_vol,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_samples,
        input  in_vol,
        output in_ready
    );
endinterface

// File: rtl/audio_pwm_core.sv
// PWM counter, duty register and registered 1-bit output.
// AUDIO_MIX_CHOP_EN adds a per-period phase bit that alternates left- and right-aligned pulses.
module audio_pwm_core #(
    parameter int unsigned PWM_BITS = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable_i,
    input  logic                load_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                wrap_o,
    output logic                period_start_o,
    output logic                audio_o
);

    localparam logic [PWM_BITS-1:0] CntMax  = '1;
    localparam logic [PWM_BITS-1:0] DutyMid = PWM_BITS'(1 << (PWM_BITS - 1));

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                audio_q, audio_d;
    logic                period_start_q;
    logic                pulse_high;

    assign wrap_o = enable_i && (cnt_q == CntMax);

`ifdef AUDIO_MIX_CHOP_EN
    logic                phase_q;
    logic [PWM_BITS:0]   rise_at;

    // Odd periods: pulse ends at the period end, same high count as the left-aligned form.
    always_comb begin
        rise_at    = {1'b1, {PWM_BITS{1'b0}}} - {1'b0, duty_q};
        pulse_high = phase_q ? ({1'b0, cnt_q} >= rise_at) : (duty_q > cnt_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
        end else if (wrap_o) begin
            phase_q <= ~phase_q;
        end
    end
`else
    always_comb begin
        pulse_high = duty_q > cnt_q;
    end
`endif

    always_comb begin
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        audio_d = audio_q;
        if (enable_i) begin
            cnt_d   = cnt_q + 1'b1;
            audio_d = pulse_high;
        end
        if (wrap_o && load_i) begin
            duty_d = duty_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            duty_q         <= DutyMid;
            audio_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            audio_q        <= audio_d;
            period_start_q <= wrap_o;
        end
    end

    assign period_start_o = period_start_q;
    assign audio_o        = audio_q;

endmodule

// File: rtl/audio_mix_pwm.sv
// Multi-channel attenuate/mix/saturate front end feeding a 1-bit PWM audio output.
// Optional AUDIO_MIX_CHOP_EN selects alternating pulse alignment inside audio_pwm_core.
module audio_mix_pwm
    import audio_mix_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned A_BITS   = 11,
    parameter int unsigned PWM_BITS = 7,
    parameter int unsigned VOL_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    audio_mix_pwm_if.slave        bus,
    input  logic                  clip_clear,
    output logic                  clip,
    output logic                  period_start,
    output logic                  audio_out
);

    localparam int unsigned    AccW   = acc_width(CHANNELS, A_BITS);
    localparam int unsigned    ChW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [ChW-1:0] LastCh = ChW'(CHANNELS - 1);

    mix_state_e                 state_q;
    logic signed [A_BITS-1:0]   samples_q [CHANNELS];
    logic        [VOL_BITS-1:0] vols_q    [CHANNELS];
    logic signed [AccW-1:0]     acc_q;
    logic        [ChW-1:0]      ch_q;
    logic        [PWM_BITS-1:0] duty_next_q;
    logic                       clip_q;

    logic                       wrap;
    logic                       load_pending;
    logic                       last_ch;
    logic                       clip_set;
    logic signed [A_BITS-1:0]   cur_sample;
    logic        [VOL_BITS-1:0] cur_vol;
    logic signed [AccW-1:0]     term;
    logic signed [AccW-1:0]     acc_sum;
    sat_t                       sat;
    logic        [PWM_BITS-1:0] duty_conv;
    logic                       unused_sat;

    always_comb begin
        cur_sample = samples_q[ch_q];
        cur_vol    = vols_q[ch_q];
        term       = $signed({{(AccW - A_BITS){cur_sample[A_BITS-1]}}, cur_sample}) >>> cur_vol;
        acc_sum    = acc_q + term;
        sat        = sat_signed({{(SatW - AccW){acc_sum[AccW-1]}}, acc_sum}, A_BITS);
        // Offset-binary duty: top PWM_BITS of the mix with the sign bit flipped.
        duty_conv              = sat.value[A_BITS-1 -: PWM_BITS];
        duty_conv[PWM_BITS-1]  = ~duty_conv[PWM_BITS-1];
    end

    assign unused_sat   = ^sat.value;
    assign last_ch      = (ch_q == LastCh);
    assign clip_set     = (state_q == StAccum) && last_ch && sat.clipped;
    assign load_pending = (state_q == StDone);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ch_q        <= '0;
            duty_next_q <= '0;
            clip_q      <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                samples_q[i] <= '0;
                vols_q[i]    <= '0;
            end
        end else begin
            if (clip_set) begin
                clip_q <= 1'b1;
            end else if (clip_clear) begin
                clip_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < int'(CHANNELS); i++) begin
                            samples_q[i] <= bus.in_samples[i*A_BITS +: A_BITS];
                            vols_q[i]    <= bus.in_vol[i*VOL_BITS +: VOL_BITS];
                        end
                        acc_q   <= '0;
                        ch_q    <= '0;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    acc_q <= acc_sum;
                    ch_q  <= ch_q + 1'b1;
                    if (last_ch) begin
                        duty_next_q <= duty_conv;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // Hand over only at a period boundary so no period mixes two duties.
                    if (wrap) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready = (state_q == StIdle);
    assign clip         = clip_q;

    audio_pwm_core #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable_i      (enable),
        .load_i        (load_pending),
        .duty_i        (duty_next_q),
        .wrap_o        (wrap),
        .period_start_o(period_start),
        .audio_o       (audio_out)
    );

endmodule

// File: tb/tb_audio_mix_pwm.sv
// Self-checking bench for audio_mix_pwm: frame-level reference model, per-period pulse counting.
module tb_audio_mix_pwm;

    localparam int unsigned CH     = 4;
    localparam int unsigned AB     = 11;
    localparam int unsigned PB     = 7;
    localparam int unsigned VB     = 3;
    localparam int          Period = 1 << PB;
    localparam int          MixMax = (1 << (AB - 1)) - 1;
    localparam int          MixMin = -(1 << (AB - 1));

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic clip_clear;
    logic clip;
    logic period_start;
    logic audio_out;

    audio_mix_pwm_if #(.CHANNELS(CH), .A_BITS(AB), .VOL_BITS(VB)) bus ();

    audio_mix_pwm #(
        .CHANNELS(CH),
        .A_BITS  (AB),
        .PWM_BITS(PB),
        .VOL_BITS(VB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .bus         (bus),
        .clip_clear  (clip_clear),
        .clip        (clip),
        .period_start(period_start),
        .audio_out   (audio_out)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_pass     = 0;
    bit model_clip = 1'b0;
    int smp [CH];
    int vol [CH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame();
        for (int i = 0; i < int'(CH); i++) begin
            bus.in_samples[i*AB +: AB] = AB'(smp[i]);
            bus.in_vol[i*VB +: VB]     = VB'(vol[i]);
        end
    endtask

    task automatic scramble_bus();
        for (int i = 0; i < int'(CH); i++) begin
            bus.in_samples[i*AB +: AB] = AB'($urandom);
            bus.in_vol[i*VB +: VB]     = VB'($urandom);
        end
    endtask

    // Reference: sum of arithmetically shifted samples, clamped to the signed sample range.
    function automatic int model_mix(output bit clipped);
        int sum = 0;
        for (int i = 0; i < int'(CH); i++) sum += smp[i] >>> vol[i];
        clipped = (sum > MixMax) || (sum < MixMin);
        if (sum > MixMax) return MixMax;
        if (sum < MixMin) return MixMin;
        return sum;
    endfunction

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (period_start) ok = 1'b1;
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        repeat (Period) begin
            tick();
            if (audio_out) n++;
        end
    endtask

    task automatic capture(output logic [Period-1:0] pat);
        for (int j = 0; j < Period; j++) begin
            tick();
            pat[j] = audio_out;
        end
    endtask

    // Sends the frame in smp/vol, checks handshake timing, clip and the loaded duty.
    task automatic run_frame(input bit clear_during);
        bit clipped;
        bit ok;
        bit done;
        int mix;
        int duty_e;
        int highs;
        mix    = model_mix(clipped);
        duty_e = (mix + (1 << (AB - 1))) >> (AB - PB);
        ok     = bus.in_ready;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            ok = bus.in_ready;
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL frame_ready_wait: in_ready got 0, required 1");
            return;
        end
        n_pass++;
        drive_frame();
        bus.in_valid = 1'b1;
        clip_clear   = clear_during;
        tick();
        bus.in_valid = 1'b0;
        scramble_bus();
        n_checks++;
        if (bus.in_ready !== 1'b0)
            $display("FAIL busy_after_accept: in_ready got %b, required 0", bus.in_ready);
        else n_pass++;
        done = 1'b0;
        for (int k = 1; k <= 400 && !done; k++) begin
            tick();
            if (k == 4) begin
                model_clip = clipped ? 1'b1 : (clear_during ? 1'b0 : model_clip);
                n_checks++;
                if (clip !== model_clip)
                    $display("FAIL clip_at_done: clip got %b, required %b", clip, model_clip);
                else n_pass++;
                clip_clear = 1'b0;
            end
            if (period_start && k >= 5) begin
                n_checks++;
                if (bus.in_ready !== 1'b1)
                    $display("FAIL load_ready: in_ready got %b, required 1", bus.in_ready);
                else n_pass++;
                done = 1'b1;
            end else if (bus.in_ready !== 1'b0) begin
                n_checks++;
                $display("FAIL early_ready: in_ready got 1 at cycle %0d, required 0", k);
                done = 1'b1;
            end
        end
        clip_clear = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL load_timeout: no load seen, required within 400 cycles");
            return;
        end
        count_high(highs);
        n_checks++;
        if (highs !== duty_e)
            $display("FAIL duty_count: high cycles got %0d, required %0d (mix %0d)",
                     highs, duty_e, mix);
        else n_pass++;
        n_checks++;
        if (clip !== model_clip)
            $display("FAIL clip_sticky: clip got %b, required %b", clip, model_clip);
        else n_pass++;
    endtask

    task automatic pulse_clear();
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
        model_clip = 1'b0;
        n_checks++;
        if (clip !== 1'b0) $display("FAIL clip_clear: clip got %b, required 0", clip);
        else n_pass++;
    endtask

    task automatic test_reset();
        bit ok;
        int highs;
        reset_n      = 1'b0;
        enable       = 1'b0;
        clip_clear   = 1'b0;
        bus.in_valid = 1'b0;
        scramble_bus();
        repeat (3) tick();
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < int'(CH); i++) begin
            smp[i] = MixMax;
            vol[i] = 0;
        end
        drive_frame();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({clip, audio_out, period_start} !== 3'b000)
            $display("FAIL reset_outputs: clip/audio/ps got %b%b%b, required 000",
                     clip, audio_out, period_start);
        else n_pass++;
        repeat (2) tick();
        reset_n = 1'b1;
        n_checks++;
        if ({bus.in_ready, clip, audio_out} !== 3'b100)
            $display("FAIL reset_release: ready/clip/audio got %b%b%b, required 100",
                     bus.in_ready, clip, audio_out);
        else n_pass++;
        repeat (10) tick();
        n_checks++;
        if ({bus.in_ready, clip} !== 2'b10)
            $display("FAIL frame_discarded: ready/clip got %b%b, required 10",
                     bus.in_ready, clip);
        else n_pass++;
        wait_ps(ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL reset_period: period_start got none, required one");
            return;
        end
        n_pass++;
        count_high(highs);
        n_checks++;
        if (highs !== Period / 2)
            $display("FAIL reset_duty: high cycles got %0d, required %0d", highs, Period / 2);
        else n_pass++;
    endtask

    task automatic test_single_channel();
        for (int i = 0; i < int'(CH); i++) begin
            smp[i] = (i == 0) ? MixMax : 0;
            vol[i] = 0;
        end
        run_frame(1'b0);
    endtask

    task automatic test_clip();
        for (int i = 0; i < int'(CH); i++) begin
            smp[i] = MixMax;
            vol[i] = 0;
        end
        run_frame(1'b0);
        pulse_clear();
        // Clear held through the saturating frame: the set must win.
        run_frame(1'b1);
        pulse_clear();
    endtask

    task automatic test_vol_shift();
        for (int i = 0; i < int'(CH); i++) begin
            smp[i] = (i == 0) ? MixMin : 0;
            vol[i] = (i == 0) ? 1 : 0;
        end
        run_frame(1'b0);
    endtask

    task automatic test_enable_hold();
        int  h1;
        int  h2;
        bit  held;
        logic a0;
        n_checks++;
        if (period_start !== 1'b1)
            $display("FAIL period_aligned: period_start got %b, required 1", period_start);
        else n_pass++;
        h1 = 0;
        repeat (20) begin
            tick();
            if (audio_out) h1++;
        end
        enable = 1'b0;
        a0     = audio_out;
        held   = 1'b1;
        repeat (30) begin
            tick();
            if (audio_out !== a0 || period_start !== 1'b0) held = 1'b0;
        end
        n_checks++;
        if (!held || a0 !== 1'b1)
            $display("FAIL enable_hold: held got %b value %b, required 1 and 1", held, a0);
        else n_pass++;
        enable = 1'b1;
        h2 = 0;
        repeat (Period - 20) begin
            tick();
            if (audio_out) h2++;
        end
        n_checks++;
        if (h1 + h2 !== 32 || period_start !== 1'b1)
            $display("FAIL enable_gap_period: highs got %0d ps %b, required 32 and 1",
                     h1 + h2, period_start);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < int'(CH); i++) begin
                if (f % 3 == 0) smp[i] = int'($urandom_range(700, 1023));
                else            smp[i] = int'($urandom_range(0, 2047)) - 1024;
                vol[i] = (f % 3 == 0) ? 0 : int'($urandom_range(0, 7));
            end
            run_frame(1'b0);
            if (model_clip) pulse_clear();
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit got;
        int readies;
        bus.in_valid = 1'b1;
        wait_ps(ok);
        if (ok) wait_ps(ok);
        if (!ok) begin
            n_checks++;
            $display("FAIL b2b_sync: period_start got none, required one");
            bus.in_valid = 1'b0;
            return;
        end
        for (int w = 0; w < 3; w++) begin
            readies = bus.in_ready ? 1 : 0;
            got     = 1'b0;
            for (int i = 0; i < 300 && !got; i++) begin
                scramble_bus();
                tick();
                if (period_start) got = 1'b1;
                else if (bus.in_ready) readies++;
            end
            n_checks++;
            if (!got || readies !== 1)
                $display("FAIL b2b_accepts: accepts in period %0d got %0d, required 1",
                         w, readies);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        ok = bus.in_ready;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            ok = bus.in_ready;
        end
        pulse_clear();
    endtask

`ifdef AUDIO_MIX_CHOP_EN
    task automatic test_chop();
        logic [Period-1:0] p0;
        logic [Period-1:0] p1;
        logic [Period-1:0] left;
        logic [Period-1:0] right;
        left  = (Period'(1) << 10) - Period'(1);
        right = left << (Period - 10);
        for (int i = 0; i < int'(CH); i++) begin
            smp[i] = (i == 0) ? -864 : 0;
            vol[i] = 0;
        end
        run_frame(1'b0);
        capture(p0);
        capture(p1);
        n_checks++;
        if (!((p0 === left && p1 === right) || (p0 === right && p1 === left)))
            $display("FAIL chop_shape: periods got %h %h, required %h and %h alternating",
                     p0, p1, left, right);
        else n_pass++;
        for (int i = 0; i < int'(CH); i++) smp[i] = (i == 0) ? MixMin : 0;
        run_frame(1'b0);
        capture(p0);
        capture(p1);
        n_checks++;
        if ((p0 | p1) !== '0)
            $display("FAIL chop_zero: pattern got %h %h, required all zero", p0, p1);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_channel();
        test_clip();
        test_vol_shift();
        test_enable_hold();
        test_random();
        test_back_to_back();
`ifdef AUDIO_MIX_CHOP_EN
        test_chop();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time got 2000000, required earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
